i2s_audio_out: RTL and testbench

- Final output stage of the synth engine, directly downstream of the stereo mixer.
- Accepts one signed 16-bit L/R sample pair per mixer frame and holds it in a two-stage buffer (pending, active).
- Serialises the active pair as a Philips I2S stream (BCLK, LRCK, SDATA) for the codec.
- Reports underrun/overrun and gives the mixer a frame-request pulse so it can align its voice scan.

---
 rtl/i2s_audio_out.sv | 166 ++++++++++++++++
 tb/tb_i2s_audio_out.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_audio_out.sv
// Purpose: I2S (Philips) serialiser for the synth output: pending/active pair buffer, BCLK/LRCK/SDATA, flags.
// Latency: a pair accepted during frame N is transmitted in frame N+1; its MSB appears one BCLK after the LRCK edge.
// Backpressure: none; the mixer is paced by frame_req, a late pair repeats the last one (underrun), an extra pair overwrites (overrun).
// Optional build macro SOFT_MUTE_EN: per-frame gain ramp replaces the hard mute.
module i2s_audio_out #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        sCLK_XVXENVS,
  input  logic        iRST,
  input  logic [15:0] lsound_in,
  input  logic [15:0] rsound_in,
  input  logic        sample_valid,
  input  logic        mute,
  input  logic        clr_flags,
  output logic        oBCLK,
  output logic        oLRCK,
  output logic        oSDATA,
  output logic        frame_req,
  output logic        underrun,
  output logic        overrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] slot_idx;
  logic [3:0]       bit_idx;
  logic             div_wrap;
  logic             fall_evt;
  logic             boundary;
  logic             in_right;
  logic             sdata_nxt;
  logic [15:0]      pend_l, pend_r;
  logic [15:0]      act_l, act_r;
  logic [15:0]      out_l, out_r;
  logic [15:0]      chan;
  logic             pend_full;

  // A fall event is the divider wrap while BCLK is high; the boundary is the fall that wraps bit_cnt to 0.
  assign div_wrap = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall_evt = div_wrap && oBCLK;
  assign bit_nxt  = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
  assign boundary = fall_evt && (bit_nxt == '0);

`ifdef SOFT_MUTE_EN
  logic [7:0]         gain;
  logic signed [24:0] prod_l, prod_r;

  // Gain walks one step per frame toward 128 (unmuted) or 0 (muted), saturating at both ends.
  always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
    if (iRST) begin
      gain <= 8'd0;
    end else if (boundary) begin
      if (mute) begin
        if (gain != 8'd0) gain <= gain - 8'd1;
      end else begin
        if (gain != 8'd128) gain <= gain + 8'd1;
      end
    end
  end

  // Scale the active pair; gain <= 128 so the shifted product always fits 16 bits.
  always_comb begin
    prod_l = $signed(act_l) * $signed({1'b0, gain});
    prod_r = $signed(act_r) * $signed({1'b0, gain});
    out_l  = 16'(prod_l >>> 7);
    out_r  = 16'(prod_r >>> 7);
  end
`else
  assign out_l = act_l;
  assign out_r = act_r;
`endif

  // Decode the next bit position into channel, slot index and sample bit (slot bits 1..16 carry data, MSB first).
  always_comb begin
    in_right  = (bit_nxt >= BIT_W'(SLOT_BITS));
    slot_idx  = in_right ? (bit_nxt - BIT_W'(SLOT_BITS)) : bit_nxt;
    bit_idx   = 4'(BIT_W'(16) - slot_idx);
    chan      = in_right ? out_r : out_l;
    sdata_nxt = 1'b0;
    if ((slot_idx >= BIT_W'(1)) && (slot_idx <= BIT_W'(16))) sdata_nxt = chan[bit_idx];
  end

  // BCLK divider: toggle the bit clock every BCLK_DIV system clocks.
  always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
    if (iRST) begin
      div_cnt <= '0;
      oBCLK   <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      oBCLK   <= ~oBCLK;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Serialiser: LRCK and SDATA only change on BCLK falls so the codec samples stable data on the rise.
  always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
    if (iRST) begin
      bit_cnt <= '0;
      oLRCK   <= 1'b0;
      oSDATA  <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt <= bit_nxt;
      oLRCK   <= in_right;
      oSDATA  <= sdata_nxt;
    end
  end

  // Two-stage buffer: capture into pending, promote to active on each frame boundary.
  always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
    if (iRST) begin
      pend_l    <= '0;
      pend_r    <= '0;
      act_l     <= '0;
      act_r     <= '0;
      pend_full <= 1'b0;
    end else begin
      if (boundary) begin
`ifdef SOFT_MUTE_EN
        if (pend_full) begin
          act_l <= pend_l;
          act_r <= pend_r;
        end
`else
        if (mute) begin
          act_l <= '0;
          act_r <= '0;
        end else if (pend_full) begin
          act_l <= pend_l;
          act_r <= pend_r;
        end
`endif
      end
      // A pair arriving on the boundary cycle lands behind the one being promoted.
      if (sample_valid) begin
        pend_l    <= lsound_in;
        pend_r    <= rsound_in;
        pend_full <= 1'b1;
      end else if (boundary) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Sticky flags (set beats clear) and the one-cycle frame request after each boundary.
  always_ff @(posedge sCLK_XVXENVS or posedge iRST) begin
    if (iRST) begin
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      frame_req <= 1'b0;
    end else begin
      frame_req <= boundary;
      if (boundary && !pend_full) underrun <= 1'b1;
      else if (clr_flags)         underrun <= 1'b0;
      if (sample_valid && pend_full && !boundary) overrun <= 1'b1;
      else if (clr_flags)                         overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_audio_out.sv
// Directed bench for i2s_audio_out with BCLK_DIV = 2, SLOT_BITS = 32 (frame = 256 system clocks).
// Each frame is captured bit by bit just after every BCLK fall and reassembled into L/R words.
module tb_i2s_audio_out;

  localparam logic [63:0] LR_PAT = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lsound_in, rsound_in;
  logic        sample_valid, mute, clr_flags;
  logic        oBCLK, oLRCK, oSDATA, frame_req, underrun, overrun;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2s_audio_out #(.BCLK_DIV(2), .SLOT_BITS(32)) dut (
    .sCLK_XVXENVS(clk),
    .iRST        (rst),
    .lsound_in   (lsound_in),
    .rsound_in   (rsound_in),
    .sample_valid(sample_valid),
    .mute        (mute),
    .clr_flags   (clr_flags),
    .oBCLK       (oBCLK),
    .oLRCK       (oLRCK),
    .oSDATA      (oSDATA),
    .frame_req   (frame_req),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the frame request pulse; returns the number of negedges waited.
  task automatic wait_req(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_req && n < 600);
    chk({tag, ".req_seen"}, frame_req, 1);
  endtask

  // One-cycle strobe of a sample pair, starting at the current negedge.
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    lsound_in    = l;
    rsound_in    = r;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  // Called right after a boundary: samples bits b = 1..63, then checks words, padding, LRCK and frame_req.
  task automatic check_frame(input string tag, input logic [15:0] exp_l, input logic [15:0] exp_r);
    logic [63:0] sd, lr;
    logic [15:0] l, r;
    int reqs;
    sd = '0;
    lr = '0;
    reqs = 0;
    for (int b = 1; b < 64; b++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (frame_req) reqs++;
      end
      sd[b] = oSDATA;
      lr[b] = oLRCK;
    end
    for (int i = 0; i < 16; i++) begin
      l[15-i] = sd[1+i];
      r[15-i] = sd[33+i];
    end
    chk({tag, ".left"}, l, exp_l);
    chk({tag, ".right"}, r, exp_r);
    chk({tag, ".pad"}, sd & ~DATA_MASK, 0);
    chk({tag, ".lrck"}, lr, LR_PAT);
    chk({tag, ".req_count"}, reqs, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    lsound_in = '0;
    rsound_in = '0;
    sample_valid = 1'b0;
    mute = 1'b0;
    clr_flags = 1'b0;

    // Reset state and BCLK period after release
    repeat (3) @(negedge clk);
    chk("reset_outs", {oBCLK, oLRCK, oSDATA, frame_req, underrun, overrun}, 0);
    rst = 1'b0;
    @(negedge clk); chk("bclk_c1", oBCLK, 0);
    @(negedge clk); chk("bclk_c2", oBCLK, 1);
    @(negedge clk); chk("bclk_c3", oBCLK, 1);
    @(negedge clk); chk("bclk_c4", oBCLK, 0);
    chk("lrck_c4", oLRCK, 0);

    // Idle: first boundary 256 clocks after release, underrun, zeros out
    wait_req("first", n);
    chk("first_boundary_time", n, 252);
    chk("idle_underrun", underrun, 1);
    chk("idle_overrun", overrun, 0);
    check_frame("idle", 16'h0000, 16'h0000);

    // Single pair
    pulse_clr();
    chk("clr_underrun", underrun, 0);
    send(16'h8001, 16'h7FFE);
    wait_req("single", n);
    chk("single_underrun", underrun, 0);
    check_frame("single", 16'h8001, 16'h7FFE);
    chk("single_overrun", overrun, 0);

    // No new pair: repeat and underrun, then clear
    wait_req("repeat", n);
    chk("repeat_underrun", underrun, 1);
    check_frame("repeat", 16'h8001, 16'h7FFE);
    pulse_clr();
    chk("repeat_clr", underrun, 0);

    // Two pairs in one frame: overrun, newest wins
    send(16'h1111, 16'h1111);
    send(16'h2222, 16'hDDDD);
    chk("overrun_set", overrun, 1);
    wait_req("overrun", n);
    chk("overrun_underrun", underrun, 0);
    check_frame("overrun", 16'h2222, 16'hDDDD);
    pulse_clr();
    chk("overrun_clr", overrun, 0);

    // Pair on the boundary cycle itself: old pending goes out, new one follows
    send(16'h3333, 16'hCCCC);
    @(negedge clk);
    send(16'h4444, 16'hBBBB);
    chk("coincide_req", frame_req, 1);
    chk("coincide_overrun", overrun, 0);
    check_frame("coincide_old", 16'h3333, 16'hCCCC);
    wait_req("coincide", n);
    chk("coincide_underrun", underrun, 0);
    check_frame("coincide_new", 16'h4444, 16'hBBBB);
    chk("coincide_overrun2", overrun, 0);

    // Hard mute at the boundary loads zeros
    send(16'h5555, 16'hAAAA);
    mute = 1'b1;
    wait_req("mute", n);
    mute = 1'b0;
    chk("mute_underrun", underrun, 0);
    check_frame("mute", 16'h0000, 16'h0000);

    // Reset during the right slot
    send(16'h6666, 16'h9999);
    send(16'h7777, 16'h8888);
    chk("pre_reset", {oBCLK, oLRCK, overrun}, 3'b111);
    rst = 1'b1;
    #1;
    chk("reset_async", {oBCLK, oLRCK, oSDATA, frame_req, underrun, overrun}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); chk("post_bclk_c1", oBCLK, 0);
    @(negedge clk); chk("post_bclk_c2", oBCLK, 1);
    wait_req("post", n);
    chk("post_boundary_time", n, 254);
    chk("post_underrun", underrun, 1);
    check_frame("post_reset", 16'h0000, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
